// File: rtl/wb_io_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : wb_io_ctrl
// Purpose  : Wishbone slave for user IO pads: output/enable registers,
//            synchronized inputs and rising-edge interrupt capture.
// Revision : 1.0 - initial release
// ============================================================================
module wb_io_ctrl #(
    parameter logic [31:0] BASE_ADR = 32'h3000_0000,
    parameter int          NIO      = 38
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    input  logic             wbs_stb_i,
    input  logic             wbs_cyc_i,
    input  logic             wbs_we_i,
    input  logic [3:0]       wbs_sel_i,
    input  logic [31:0]      wbs_dat_i,
    input  logic [31:0]      wbs_adr_i,
    output logic             wbs_ack_o,
    output logic [31:0]      wbs_dat_o,
    input  logic             io_active,
    input  logic [NIO-1:0]   io_in,
    output logic [NIO-1:0]   io_out,
    output logic [NIO-1:0]   io_oeb,
    output logic             irq
);
    localparam int HI_W = NIO - 32;

    localparam logic [5:0] c_OUT_LO   = 6'd0;
    localparam logic [5:0] c_OUT_HI   = 6'd1;
    localparam logic [5:0] c_OEB_LO   = 6'd2;
    localparam logic [5:0] c_OEB_HI   = 6'd3;
    localparam logic [5:0] c_IN_LO    = 6'd4;
    localparam logic [5:0] c_IN_HI    = 6'd5;
    localparam logic [5:0] c_IRQ_EN   = 6'd6;
    localparam logic [5:0] c_IRQ_STAT = 6'd7;

    logic            w_sel;
    logic            w_access;
    logic            w_wr;
    logic [5:0]      w_off;
    logic [31:0]     w_lane_mask;
    logic [31:0]     w_rdata;
    logic [31:0]     w_rise;
    logic [31:0]     w_w1c;
    logic [31:0]     w_out_hi_new;
    logic [31:0]     w_oeb_hi_new;
    logic            w_unused;

    logic [31:0]     r_out_lo;
    logic [HI_W-1:0] r_out_hi;
    logic [31:0]     r_oeb_lo;
    logic [HI_W-1:0] r_oeb_hi;
    logic [31:0]     r_irq_en;
    logic [31:0]     r_irq_stat;
    logic [NIO-1:0]  r_sync1;
    logic [NIO-1:0]  r_sync2;
    logic [31:0]     r_sync3;

    function automatic logic [31:0] lane_merge(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [31:0] mask);
        return (old_val & ~mask) | (new_val & mask);
    endfunction

    assign w_sel       = wbs_stb_i & wbs_cyc_i & (wbs_adr_i[31:8] == BASE_ADR[31:8]);
    // An access is taken only on the cycle ack is low, so a held strobe never double-acks.
    assign w_access    = w_sel & ~wbs_ack_o;
    assign w_wr        = w_access & wbs_we_i;
    assign w_off       = wbs_adr_i[7:2];
    assign w_lane_mask = {{8{wbs_sel_i[3]}}, {8{wbs_sel_i[2]}},
                          {8{wbs_sel_i[1]}}, {8{wbs_sel_i[0]}}};
    assign w_rise      = r_sync2[31:0] & ~r_sync3;
    assign w_w1c       = (w_wr && (w_off == c_IRQ_STAT)) ? (wbs_dat_i & w_lane_mask) : 32'h0;
    assign w_out_hi_new = lane_merge(32'(r_out_hi), wbs_dat_i, w_lane_mask);
    assign w_oeb_hi_new = lane_merge(32'(r_oeb_hi), wbs_dat_i, w_lane_mask);
    assign w_unused    = &{1'b0, wbs_adr_i[1:0], w_out_hi_new[31:HI_W], w_oeb_hi_new[31:HI_W]};

    always_comb begin
        w_rdata = 32'h0;
        case (w_off)
            c_OUT_LO:   w_rdata = r_out_lo;
            c_OUT_HI:   w_rdata = 32'(r_out_hi);
            c_OEB_LO:   w_rdata = r_oeb_lo;
            c_OEB_HI:   w_rdata = 32'(r_oeb_hi);
            c_IN_LO:    w_rdata = r_sync2[31:0];
            c_IN_HI:    w_rdata = 32'(r_sync2[NIO-1:32]);
            c_IRQ_EN:   w_rdata = r_irq_en;
            c_IRQ_STAT: w_rdata = r_irq_stat;
            default:    w_rdata = 32'h0;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            wbs_ack_o  <= 1'b0;
            wbs_dat_o  <= 32'h0;
            r_out_lo   <= 32'h0;
            r_out_hi   <= '0;
            r_oeb_lo   <= 32'hFFFF_FFFF;
            r_oeb_hi   <= '1;
            r_irq_en   <= 32'h0;
            r_irq_stat <= 32'h0;
            r_sync1    <= '0;
            r_sync2    <= '0;
            r_sync3    <= 32'h0;
        end else begin
            wbs_ack_o  <= w_access;
            wbs_dat_o  <= w_access ? w_rdata : 32'h0;
            r_sync1    <= io_in;
            r_sync2    <= r_sync1;
            r_sync3    <= r_sync2[31:0];
            // New edges are OR-ed in after the clear so a coincident rise survives.
            r_irq_stat <= (r_irq_stat & ~w_w1c) | w_rise;
            if (w_wr) begin
                case (w_off)
                    c_OUT_LO: r_out_lo <= lane_merge(r_out_lo, wbs_dat_i, w_lane_mask);
                    c_OUT_HI: r_out_hi <= w_out_hi_new[HI_W-1:0];
                    c_OEB_LO: r_oeb_lo <= lane_merge(r_oeb_lo, wbs_dat_i, w_lane_mask);
                    c_OEB_HI: r_oeb_hi <= w_oeb_hi_new[HI_W-1:0];
                    c_IRQ_EN: r_irq_en <= lane_merge(r_irq_en, wbs_dat_i, w_lane_mask);
                    default: ;
                endcase
            end
        end
    end

    assign io_out = io_active ? {r_out_hi, r_out_lo} : '0;
    assign io_oeb = io_active ? {r_oeb_hi, r_oeb_lo} : '1;
    assign irq    = |(r_irq_stat & r_irq_en);

endmodule
`default_nettype wire

// File: tb/tb_wb_io_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_io_ctrl
// Purpose  : Directed and randomized bench for wb_io_ctrl with a
//            register-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_wb_io_ctrl;
    localparam logic [31:0] c_BASE = 32'h3000_0000;
    localparam int          c_NIO  = 38;

    logic             clk;
    logic             rst;
    logic             stb, cyc, we;
    logic [3:0]       sel;
    logic [31:0]      dat_i, adr;
    logic             ack;
    logic [31:0]      dat_o;
    logic             io_active;
    logic [c_NIO-1:0] io_in, io_out, io_oeb;
    logic             irq;

    int n_tests = 0;
    int n_fail  = 0;

    wb_io_ctrl #(.BASE_ADR(c_BASE), .NIO(c_NIO)) dut (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .wbs_stb_i(stb),
        .wbs_cyc_i(cyc),
        .wbs_we_i (we),
        .wbs_sel_i(sel),
        .wbs_dat_i(dat_i),
        .wbs_adr_i(adr),
        .wbs_ack_o(ack),
        .wbs_dat_o(dat_o),
        .io_active(io_active),
        .io_in    (io_in),
        .io_out   (io_out),
        .io_oeb   (io_oeb),
        .irq      (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: registers by word index, pad input history by edge.
    logic [31:0]      m_reg  [0:7];
    logic [c_NIO-1:0] m_hist [0:2];
    logic [31:0]      m_rd;
    bit               m_busy;

    always @(posedge clk) begin
        logic [31:0] lane, w1c, rise, rd;
        logic [5:0]  off;
        bit          hit;
        if (rst) begin
            for (int i = 0; i < 8; i++) m_reg[i] = 32'h0;
            m_reg[2] = 32'hFFFF_FFFF;
            m_reg[3] = 32'h3F;
            for (int i = 0; i < 3; i++) m_hist[i] = '0;
            m_busy = 0;
        end else begin
            rise = m_hist[1][31:0] & ~m_hist[2][31:0];
            w1c  = 32'h0;
            hit  = stb && cyc && (adr[31:8] == c_BASE[31:8]);
            if (hit && !m_busy) begin
                off  = adr[7:2];
                lane = {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
                if (off == 6'd4)      rd = m_hist[1][31:0];
                else if (off == 6'd5) rd = {26'h0, m_hist[1][37:32]};
                else if (off < 6'd8)  rd = m_reg[off[2:0]];
                else                  rd = 32'h0;
                m_rd = rd;
                if (we) begin
                    case (off)
                        6'd0, 6'd2, 6'd6: m_reg[off[2:0]] = (m_reg[off[2:0]] & ~lane) | (dat_i & lane);
                        6'd1, 6'd3:       m_reg[off[2:0]] = ((m_reg[off[2:0]] & ~lane) | (dat_i & lane)) & 32'h3F;
                        6'd7:             w1c = dat_i & lane;
                        default: ;
                    endcase
                end
            end
            m_busy   = hit && !m_busy;
            m_reg[7] = (m_reg[7] & ~w1c) | rise;
            m_hist[2] = m_hist[1];
            m_hist[1] = m_hist[0];
            m_hist[0] = io_in;
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_pins();
        chk("io_out", 64'(io_out), io_active ? 64'({m_reg[1][5:0], m_reg[0]}) : 64'h0);
        chk("io_oeb", 64'(io_oeb), io_active ? 64'({m_reg[3][5:0], m_reg[2]}) : 64'(38'h3F_FFFF_FFFF));
        chk("irq", 64'(irq), 64'(|(m_reg[7] & m_reg[6])));
    endtask

    task automatic wb_xfer(input logic w, input logic [31:0] a, input logic [3:0] s,
                           input logic [31:0] d, output logic [31:0] rd);
        bit hit;
        hit = (a[31:8] == c_BASE[31:8]);
        @(negedge clk);
        stb = 1'b1; cyc = 1'b1; we = w; adr = a; sel = s; dat_i = d;
        @(posedge clk); #1;
        rd = dat_o;
        chk("ack_rise", 64'(ack), 64'(hit));
        if (hit && !w) chk("rdata", 64'(dat_o), 64'(m_rd));
        stb = 1'b0; cyc = 1'b0; we = 1'b0;
        @(posedge clk); #1;
        chk("ack_fall", 64'(ack), 64'h0);
        chk("dat_idle", 64'(dat_o), 64'h0);
        check_pins();
    endtask

    initial begin
        logic [31:0] rd;
        logic [5:0]  off;
        logic [31:0] a;
        rst = 1'b1; stb = 1'b0; cyc = 1'b0; we = 1'b0; sel = 4'h0;
        dat_i = 32'h0; adr = 32'h0; io_active = 1'b0; io_in = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_ack", 64'(ack), 64'h0);
        chk("rst_dat", 64'(dat_o), 64'h0);
        chk("rst_irq", 64'(irq), 64'h0);
        chk("rst_oeb_inactive", 64'(io_oeb), 64'(38'h3F_FFFF_FFFF));
        io_active = 1'b1;
        #1;
        chk("rst_io_out", 64'(io_out), 64'h0);
        chk("rst_io_oeb", 64'(io_oeb), 64'(38'h3F_FFFF_FFFF));

        // Reset values of the enable registers
        wb_xfer(1'b0, c_BASE + 32'h08, 4'hF, 32'h0, rd);
        chk("oeb_lo_rst", 64'(rd), 64'hFFFF_FFFF);
        wb_xfer(1'b0, c_BASE + 32'h0C, 4'hF, 32'h0, rd);
        chk("oeb_hi_rst", 64'(rd), 64'h3F);

        // Partial byte-lane write
        wb_xfer(1'b1, c_BASE + 32'h00, 4'b0011, 32'hA5A5_1234, rd);
        wb_xfer(1'b0, c_BASE + 32'h00, 4'hF, 32'h0, rd);
        chk("out_lo_lanes", 64'(rd), 64'h0000_1234);
        chk("io_out_lo16", 64'(io_out[15:0]), 64'h1234);

        // Pad gating by io_active
        wb_xfer(1'b1, c_BASE + 32'h08, 4'hF, 32'h0000_0000, rd);
        wb_xfer(1'b1, c_BASE + 32'h04, 4'hF, 32'hFFFF_FF2A, rd);
        @(negedge clk); io_active = 1'b0; #1;
        chk("inactive_out", 64'(io_out), 64'h0);
        chk("inactive_oeb", 64'(io_oeb), 64'(38'h3F_FFFF_FFFF));
        @(negedge clk); io_active = 1'b1; #1;
        chk("active_out", 64'(io_out), 64'(38'h2A_0000_1234));
        chk("active_oeb", 64'(io_oeb), 64'(38'h3F_0000_0000));

        // Rising edge on io_in[3] -> interrupt three edges later
        wb_xfer(1'b1, c_BASE + 32'h18, 4'hF, 32'h0000_0008, rd);
        @(negedge clk); io_in[3] = 1'b1;
        @(posedge clk); #1; chk("irq_edge1", 64'(irq), 64'h0);
        @(posedge clk); #1; chk("irq_edge2", 64'(irq), 64'h0);
        @(posedge clk); #1; chk("irq_edge3", 64'(irq), 64'h1);
        wb_xfer(1'b0, c_BASE + 32'h1C, 4'hF, 32'h0, rd);
        chk("stat_bit3", 64'(rd & 32'h8), 64'h8);
        wb_xfer(1'b1, c_BASE + 32'h1C, 4'hF, 32'h0000_0008, rd);
        chk("irq_cleared", 64'(irq), 64'h0);

        // Clear coinciding with a fresh rise: set wins
        @(negedge clk); io_in[3] = 1'b0;
        repeat (4) @(negedge clk);
        io_in[3] = 1'b1;
        @(negedge clk);
        wb_xfer(1'b1, c_BASE + 32'h1C, 4'hF, 32'h0000_0008, rd);
        wb_xfer(1'b0, c_BASE + 32'h1C, 4'hF, 32'h0, rd);
        chk("set_wins", 64'(rd & 32'h8), 64'h8);
        chk("set_wins_irq", 64'(irq), 64'h1);

        // Out-of-map, base miss, reset mid-transfer
        wb_xfer(1'b0, c_BASE + 32'h40, 4'hF, 32'h0, rd);
        chk("unmapped_rd", 64'(rd), 64'h0);
        wb_xfer(1'b1, c_BASE + 32'h40, 4'hF, 32'hDEAD_BEEF, rd);
        wb_xfer(1'b0, c_BASE + 32'h100, 4'hF, 32'h0, rd);
        wb_xfer(1'b1, c_BASE + 32'h10, 4'hF, 32'hFFFF_FFFF, rd);
        @(negedge clk);
        stb = 1'b1; cyc = 1'b1; we = 1'b1; adr = c_BASE + 32'h00; sel = 4'hF;
        dat_i = 32'h5555_AAAA; rst = 1'b1;
        @(posedge clk); #1; chk("rst_abort_ack1", 64'(ack), 64'h0);
        @(posedge clk); #1; chk("rst_abort_ack2", 64'(ack), 64'h0);
        @(negedge clk); stb = 1'b0; cyc = 1'b0; we = 1'b0; rst = 1'b0;
        wb_xfer(1'b0, c_BASE + 32'h00, 4'hF, 32'h0, rd);
        chk("rst_abort_out", 64'(rd), 64'h0);

        // Randomized traffic against the model
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 3) == 0) io_in = {$urandom, $urandom};
            if ($urandom_range(0, 7) == 0) io_active = ~io_active;
            off = 6'($urandom_range(0, 17));
            a = c_BASE | {24'h0, off, 2'b00};
            if ($urandom_range(0, 9) == 0) a = a ^ (32'h1 << $urandom_range(8, 31));
            wb_xfer(1'($urandom_range(0, 1)), a, 4'($urandom), $urandom, rd);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
